// File: rtl/sevenseg_pkg.sv
// Shared definitions for the seven-segment scanner: digit-code field
// positions, the digit-code type and the hex glyph table.
package sevenseg_pkg;

  // Field positions inside a 7-bit digit code
  localparam int BLANK_B = 6;
  localparam int DP_B    = 5;
  localparam int DASH_B  = 4;

  typedef logic [6:0] digit_code_t;

  localparam digit_code_t CODE_BLANK = 7'h40;

  // Active-low "all segments off"
  localparam logic [6:0] SEG_OFF = 7'h7F;

  // Active-high glyphs, bit 0 = segment a ... bit 6 = segment g
  localparam logic [6:0] GLYPH_DASH = 7'h40;
  localparam logic [6:0] HEX_GLYPH [16] = '{
    7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
    7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71
  };

  // Active-low glyph for a hex nibble
  function automatic logic [6:0] hex_glyph_n(input logic [3:0] v);
    return ~HEX_GLYPH[v];
  endfunction

endpackage

// File: rtl/sevenseg_scan_ctl_if.sv
// Display bus between digit producers and the scanner.
// master = producer/board side, slave = scanner.
// With SEEVENSEG-style blink enabled (macro SEVENSEG_BLINK_EN) a per-digit
// blink mask is added.
interface sevenseg_scan_ctl_if #(
  parameter int NDIG  = 8,
  parameter int DIM_W = 4
);
  logic [7*NDIG-1:0] digits;
  logic [DIM_W-1:0]  bright;
`ifdef SEVENSEG_BLINK_EN
  logic [NDIG-1:0]   blink;
`endif
  logic [6:0]        segs_n;
  logic              dp_n;
  logic [NDIG-1:0]   an_n;
  logic              frame_start;

`ifdef SEVENSEG_BLINK_EN
  modport master (output digits, bright, blink, input segs_n, dp_n, an_n, frame_start);
  modport slave  (input digits, bright, blink, output segs_n, dp_n, an_n, frame_start);
`else
  modport master (output digits, bright, input segs_n, dp_n, an_n, frame_start);
  modport slave  (input digits, bright, output segs_n, dp_n, an_n, frame_start);
`endif

endinterface

// File: rtl/sevenseg_ext_n.sv
// Extended seven-segment decoder with active-low outputs.
// Blank overrides everything (including dp), dash lights segment g only,
// otherwise a standard hex glyph is shown.
module sevenseg_ext_n
  import sevenseg_pkg::*;
(
  input  digit_code_t code_i,
  output logic [6:0]  segs_n_o,
  output logic        dp_n_o
);

  // Purely combinational glyph selection
  always_comb begin
    segs_n_o = hex_glyph_n(code_i[3:0]);
    dp_n_o   = ~code_i[DP_B];
    if (code_i[BLANK_B]) begin
      segs_n_o = SEG_OFF;
      dp_n_o   = 1'b1;
    end else if (code_i[DASH_B]) begin
      segs_n_o = ~GLYPH_DASH;
    end
  end

endmodule

// File: rtl/sevenseg_scan_ctl.sv
// Multiplexed common-anode seven-segment scanner with per-slot dwell time,
// guard blanking at slot start and PWM brightness.
// Optional feature macro: SEVENSEG_BLINK_EN (adds per-digit blinking).
module sevenseg_scan_ctl
  import sevenseg_pkg::*;
#(
  parameter int NDIG      = 8,
  parameter int CLK_HZ    = 100_000_000,
  parameter int SLOT_US   = 1000,
  parameter int DIM_W     = 4,
  parameter int GUARD_CYC = 16
`ifdef SEVENSEG_BLINK_EN
  ,
  parameter int BLINK_FRAMES = 250
`endif
)(
  input  logic               clk,
  input  logic               rst_n,
  sevenseg_scan_ctl_if.slave scan_if
);

  localparam int SLOT_CYC = (CLK_HZ / 1_000_000) * SLOT_US;
  localparam int SUB_CYC  = SLOT_CYC >> DIM_W;
  // One extra code point so the PWM limit can reach SLOT_CYC itself
  localparam int CYC_W    = $clog2(SLOT_CYC + 1);
  localparam int IDX_W    = (NDIG > 1) ? $clog2(NDIG) : 1;

  generate
    if ((SLOT_CYC % (2 ** DIM_W)) != 0) begin : g_chk_slot
      $fatal(1, "SLOT_CYC must be a multiple of 2**DIM_W");
    end
    if (GUARD_CYC >= SUB_CYC) begin : g_chk_guard
      $fatal(1, "GUARD_CYC must be smaller than SUB_CYC");
    end
    if (NDIG < 1 || NDIG > 16) begin : g_chk_ndig
      $fatal(1, "NDIG must be in 1..16");
    end
  endgenerate

  logic [CYC_W-1:0] cyc_q, cyc_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  digit_code_t      code_q, code_d;
  logic [DIM_W-1:0] bright_q, bright_d;

  logic [NDIG-1:0]  an_n_q, an_n_d;
  logic [6:0]       segs_n_q;
  logic             dp_n_q;
  logic             frame_start_q;

  digit_code_t      digit_arr [NDIG];
  digit_code_t      fresh_code;
  digit_code_t      slot_code;
  logic [DIM_W-1:0] slot_bright;
  logic [CYC_W-1:0] on_lim;
  logic             anode_on;
  logic             frame_evt;
  logic [6:0]       dec_segs_n;
  logic             dec_dp_n;

  genvar gi;
  generate
    for (gi = 0; gi < NDIG; gi++) begin : g_unpack
      assign digit_arr[gi] = scan_if.digits[7*gi +: 7];
    end
  endgenerate

  assign frame_evt = (cyc_q == '0) && (idx_q == '0);

`ifdef SEVENSEG_BLINK_EN
  localparam int FC_W = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

  logic [FC_W-1:0] fc_q, fc_d;
  logic            phase_q, phase_d;

  // Frame counter: flip the blink phase every BLINK_FRAMES frames
  always_comb begin
    fc_d    = fc_q;
    phase_d = phase_q;
    if (frame_evt) begin
      if (fc_q == FC_W'(BLINK_FRAMES - 1)) begin
        fc_d    = '0;
        phase_d = ~phase_q;
      end else begin
        fc_d = fc_q + 1'b1;
      end
    end
  end

  // Blink phase state; phase 0 (visible) out of reset
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fc_q    <= '0;
      phase_q <= 1'b0;
    end else begin
      fc_q    <= fc_d;
      phase_q <= phase_d;
    end
  end

  // Code captured at slot start, forced blank during the hidden blink phase
  always_comb begin
    fresh_code = digit_arr[idx_q];
    if (phase_q && scan_if.blink[idx_q]) fresh_code[BLANK_B] = 1'b1;
  end
`else
  // Code captured at slot start
  always_comb begin
    fresh_code = digit_arr[idx_q];
  end
`endif

  // During the first cycle of a slot the registers are only being loaded,
  // so bypass them; this keeps segments constant over the whole slot.
  always_comb begin
    slot_code   = (cyc_q == '0) ? fresh_code : code_q;
    slot_bright = (cyc_q == '0) ? scan_if.bright : bright_q;
  end

  // Slot timing, digit index and slot-start latching
  always_comb begin
    cyc_d    = cyc_q + 1'b1;
    idx_d    = idx_q;
    code_d   = code_q;
    bright_d = bright_q;
    if (cyc_q == CYC_W'(SLOT_CYC - 1)) begin
      cyc_d = '0;
      idx_d = (idx_q == IDX_W'(NDIG - 1)) ? '0 : idx_q + 1'b1;
    end
    if (cyc_q == '0) begin
      code_d   = fresh_code;
      bright_d = scan_if.bright;
    end
  end

  // Scan state registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cyc_q    <= '0;
      idx_q    <= '0;
      code_q   <= CODE_BLANK;
      bright_q <= '0;
    end else begin
      cyc_q    <= cyc_d;
      idx_q    <= idx_d;
      code_q   <= code_d;
      bright_q <= bright_d;
    end
  end

  // PWM: cyc/SUB_CYC <= bright is the same as cyc < (bright+1)*SUB_CYC
  always_comb begin
    on_lim   = CYC_W'((int'(slot_bright) + 1) * SUB_CYC);
    anode_on = (cyc_q >= CYC_W'(GUARD_CYC)) && (cyc_q < on_lim);
  end

  generate
    for (gi = 0; gi < NDIG; gi++) begin : g_anode
      assign an_n_d[gi] = !(anode_on && (idx_q == IDX_W'(gi)));
    end
  endgenerate

  sevenseg_ext_n u_dec (
    .code_i   (slot_code),
    .segs_n_o (dec_segs_n),
    .dp_n_o   (dec_dp_n)
  );

  // Registered pin drivers, one cycle behind the scan state
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      an_n_q        <= '1;
      segs_n_q      <= SEG_OFF;
      dp_n_q        <= 1'b1;
      frame_start_q <= 1'b0;
    end else begin
      an_n_q        <= an_n_d;
      segs_n_q      <= dec_segs_n;
      dp_n_q        <= dec_dp_n;
      frame_start_q <= frame_evt;
    end
  end

  assign scan_if.an_n        = an_n_q;
  assign scan_if.segs_n      = segs_n_q;
  assign scan_if.dp_n        = dp_n_q;
  assign scan_if.frame_start = frame_start_q;

endmodule

// File: tb/tb_sevenseg_scan_ctl.sv
// Self-checking bench for sevenseg_scan_ctl (NDIG=4, 64-cycle slots,
// 4 brightness levels, 4-cycle guard), compared against a time-based model.
module tb_sevenseg_scan_ctl;

  localparam int NDIG      = 4;
  localparam int CLK_HZ    = 1_000_000;
  localparam int SLOT_US   = 64;
  localparam int DIM_W     = 2;
  localparam int GUARD_CYC = 4;
  localparam int SLOT      = 64;
  localparam int SUB       = 16;
  localparam int FRAME     = SLOT * NDIG;
  localparam int NSLOTS    = 256;

  logic clk = 1'b0;
  logic rst_n = 1'b0;

  sevenseg_scan_ctl_if #(.NDIG(NDIG), .DIM_W(DIM_W)) scan_if ();

  sevenseg_scan_ctl #(
    .NDIG      (NDIG),
    .CLK_HZ    (CLK_HZ),
    .SLOT_US   (SLOT_US),
    .DIM_W     (DIM_W),
    .GUARD_CYC (GUARD_CYC)
  ) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .scan_if (scan_if.slave)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int t = 0;                 // cycles of scan state since reset release
  logic [6:0] cap_code;
  int cap_bright;
  int on_obs [NSLOTS];
  logic [6:0] seg_mid [NSLOTS];
  logic dp_mid [NSLOTS];
  int first_low;
  int frame_cnt;
  int frame_t0, frame_t1;

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h t=%0d", tag, act, exp, t);
    end
  endtask

  // Active-low glyph for a digit code (bit 0 = a, bit 6 = g)
  function automatic logic [6:0] ref_segs(input logic [6:0] c);
    logic [6:0] lit;
    case (c[3:0])
      4'h0: lit = 7'h3F;  4'h1: lit = 7'h06;  4'h2: lit = 7'h5B;  4'h3: lit = 7'h4F;
      4'h4: lit = 7'h66;  4'h5: lit = 7'h6D;  4'h6: lit = 7'h7D;  4'h7: lit = 7'h07;
      4'h8: lit = 7'h7F;  4'h9: lit = 7'h6F;  4'hA: lit = 7'h77;  4'hB: lit = 7'h7C;
      4'hC: lit = 7'h39;  4'hD: lit = 7'h5E;  4'hE: lit = 7'h79;  default: lit = 7'h71;
    endcase
    if (c[6]) return 7'h7F;
    if (c[4]) return 7'h3F;
    return ~lit;
  endfunction

  function automatic logic ref_dp(input logic [6:0] c);
    return c[6] ? 1'b1 : ~c[5];
  endfunction

  task automatic clear_obs();
    for (int i = 0; i < NSLOTS; i++) begin
      on_obs[i]  = 0;
      seg_mid[i] = 7'h00;
      dp_mid[i]  = 1'b0;
    end
    first_low = -1;
    frame_cnt = 0;
    frame_t0  = 0;
    frame_t1  = 0;
    t         = 0;
  endtask

  // One clock: the model state t is what the DUT shows one cycle later
  task automatic step();
    int cyc, idx, s;
    logic [3:0] exp_an;
    @(posedge clk);
    cyc = t % SLOT;
    idx = (t / SLOT) % NDIG;
    s   = t / SLOT;
    if (cyc == 0) begin
      cap_code   = scan_if.digits[7*idx +: 7];
      cap_bright = int'(scan_if.bright);
    end
    #1;
    exp_an = 4'hF;
    if (cyc >= GUARD_CYC && (cyc / SUB) <= cap_bright) exp_an[idx] = 1'b0;
    check_eq("an_n", 32'(scan_if.an_n), 32'(exp_an));
    check_eq("segs_n", 32'(scan_if.segs_n), 32'(ref_segs(cap_code)));
    check_eq("dp_n", 32'(scan_if.dp_n), 32'(ref_dp(cap_code)));
    check_eq("frame_start", 32'(scan_if.frame_start), 32'((t % FRAME) == 0));
    if (scan_if.an_n != 4'hF) begin
      if (s < NSLOTS) on_obs[s]++;
      if (first_low < 0) first_low = t;
    end
    if (cyc == 20 && s < NSLOTS) begin
      seg_mid[s] = scan_if.segs_n;
      dp_mid[s]  = scan_if.dp_n;
    end
    if (scan_if.frame_start) begin
      frame_cnt++;
      frame_t0 = frame_t1;
      frame_t1 = t;
    end
    t++;
  endtask

  task automatic run_to(input int tt);
    while (t < tt) step();
  endtask

  initial begin
    int tr;
    scan_if.digits = {7'h03, 7'h02, 7'h01, 7'h00};
    scan_if.bright = 2'd3;
    rst_n = 1'b0;
    clear_obs();

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    check_eq("rst_an_n", 32'(scan_if.an_n), 32'h F);
    check_eq("rst_segs_n", 32'(scan_if.segs_n), 32'h7F);
    check_eq("rst_dp_n", 32'(scan_if.dp_n), 32'h1);
    check_eq("rst_frame", 32'(scan_if.frame_start), 32'h0);
    @(posedge clk);
    #2;
    rst_n = 1'b1;
    clear_obs();

    // Digits 0..3 at full brightness for two frames
    run_to(2 * FRAME);
    check_eq("first_an_low_cycle", 32'(first_low + 1), 32'd5);
    check_eq("frame_count", 32'(frame_cnt), 32'd2);
    check_eq("frame_period", 32'(frame_t1 - frame_t0), 32'd256);
    for (int i = 0; i < NDIG; i++) check_eq("on_cycles_full", 32'(on_obs[i]), 32'd60);
    check_eq("glyph0", 32'(seg_mid[0]), 32'h40);
    check_eq("glyph1", 32'(seg_mid[1]), 32'h79);
    check_eq("glyph2", 32'(seg_mid[2]), 32'h24);
    check_eq("glyph3", 32'(seg_mid[3]), 32'h30);
    $display("phase full_bright t=%0d checks=%0d errors=%0d", t, checks, errors);

    // Dimmest, then raise brightness mid-slot 1 (cyc 30)
    scan_if.bright = 2'd0;
    run_to(2 * FRAME + SLOT + 30);
    scan_if.bright = 2'd3;
    run_to(3 * FRAME);
    check_eq("on_cycles_dim_s0", 32'(on_obs[8]), 32'd12);
    check_eq("on_cycles_dim_s1", 32'(on_obs[9]), 32'd12);
    check_eq("on_cycles_next_s2", 32'(on_obs[10]), 32'd60);
    $display("phase bright_change t=%0d checks=%0d errors=%0d", t, checks, errors);

    // Blank on digit 2, dash on digit 1
    scan_if.digits = {7'h03, 7'h40, 7'h10, 7'h00};
    run_to(4 * FRAME);
    check_eq("blank_segs", 32'(seg_mid[14]), 32'h7F);
    check_eq("blank_dp", 32'(dp_mid[14]), 32'h1);
    check_eq("blank_anode_on", 32'(on_obs[14]), 32'd60);
    check_eq("dash_segs", 32'(seg_mid[13]), 32'h3F);
    check_eq("dash_dp", 32'(dp_mid[13]), 32'h1);
    $display("phase blank_dash t=%0d checks=%0d errors=%0d", t, checks, errors);

    // Randomized codes and brightness, changed at random moments
    for (int k = 0; k < 40; k++) begin
      scan_if.digits = 28'($urandom);
      scan_if.bright = 2'($urandom_range(0, 3));
      run_to(t + int'($urandom_range(1, 90)));
    end
    $display("phase random t=%0d checks=%0d errors=%0d", t, checks, errors);

    // Asynchronous reset pulse at idx 2, cyc 40
    scan_if.digits = {7'h07, 7'h26, 7'h05, 7'h04};
    scan_if.bright = 2'd3;
    tr = ((t / FRAME) + 1) * FRAME + 2 * SLOT + 40;
    run_to(tr);
    check_eq("an_before_rst", 32'(scan_if.an_n), 32'hB);
    check_eq("segs_before_rst", 32'(scan_if.segs_n), 32'(ref_segs(7'h26)));
    #1;
    rst_n = 1'b0;
    #1;
    check_eq("async_rst_an_n", 32'(scan_if.an_n), 32'hF);
    check_eq("async_rst_segs_n", 32'(scan_if.segs_n), 32'h7F);
    check_eq("async_rst_dp_n", 32'(scan_if.dp_n), 32'h1);
    check_eq("async_rst_frame", 32'(scan_if.frame_start), 32'h0);
    @(posedge clk);
    #2;
    rst_n = 1'b1;
    clear_obs();
    run_to(FRAME + 44);
    check_eq("restart_first_low", 32'(first_low + 1), 32'd5);
    check_eq("restart_frames", 32'(frame_cnt), 32'd2);
    check_eq("restart_on_s0", 32'(on_obs[0]), 32'd60);
    check_eq("restart_glyph0", 32'(seg_mid[0]), 32'(ref_segs(7'h04)));
    $display("phase reset_restart t=%0d checks=%0d errors=%0d", t, checks, errors);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/sevenseg_scan_ctl.md
Name: sevenseg_scan_ctl

Overview:
Parametrised multiplexed seven-segment scanner. It is the successor to the fixed 8-digit, 1 ms controller, and drives any common-anode array of NDIG digits from one clock. It adds programmable per-slot dwell time, anode guard (dead-time) blanking against ghosting, and global PWM brightness. It sits between display-data producers (counters, BCD converters) and the board pins.

Parameters:
NDIG, 8, number of digits scanned; legal range 1..16.
CLK_HZ, 100_000_000, clk frequency in Hz.
SLOT_US, 1000, dwell time per digit in microseconds. SLOT_CYC = (CLK_HZ/1_000_000)*SLOT_US.
DIM_W, 4, brightness width. The slot is split into 2**DIM_W equal subphases of SUB_CYC = SLOT_CYC >> DIM_W cycles each.
GUARD_CYC, 16, cycles at the start of each slot during which all anodes are off.

Ports:
clk  in  1  system clock
rst_n  in  1  reset. One clock; reset is asynchronous and active-low.
digits  in  7*NDIG  packed digit codes; digit i is digits[7*i+6 : 7*i]. Bit 6 = blank, bit 5 = dp, bit 4 = dash, bits 3:0 = hex value.
bright  in  DIM_W  brightness level; 0 = dimmest, all ones = full.
segs_n  out  7  segments a..g, active low.
dp_n  out  1  decimal point, active low.
an_n  out  NDIG  anode enables, active low, one-hot-low.
frame_start  out  1  single-cycle pulse marking the start of each digit-0 slot.

Behaviour:
- Reset (async assert, sync release):
  - cyc = 0, idx = 0, latched code = 7'h40 (blank), latched brightness = 0.
  - an_n = all 1, segs_n = 7'h7F, dp_n = 1, frame_start = 0.
- Cycle counter cyc runs 0..SLOT_CYC-1.
  - At SLOT_CYC-1, cyc wraps to 0 and idx advances.
  - idx goes 0..NDIG-1 and wraps to 0 by explicit compare, so non-power-of-2 NDIG is legal.
  - With NDIG = 1, idx stays at 0.
- Slot start (cyc == 0): latch digits[idx] and bright into slot registers.
  - Changes to inputs mid-slot take effect in the next slot only.
  - No tearing within a slot.
- Anode on condition: (cyc >= GUARD_CYC) && ((cyc / SUB_CYC) <= latched brightness).
  - bright = 0 gives on-time SUB_CYC - GUARD_CYC.
  - bright = max gives on-time SLOT_CYC - GUARD_CYC.
- Decode of the latched code:
  - blank = 1: segs_n = 7'h7F, dp_n = 1; the anode still follows the on condition.
  - dash = 1 (blank = 0): segment g only lit.
  - Otherwise: standard hex 0–F glyphs.
  - dp_n = ~dp when not blank.
- Segments are held at their decoded value for the whole slot; only an_n is gated.
- Outputs are registered: every output reflects the internal (cyc, idx) state with 1-cycle latency.
- frame_start = 1 for exactly one cycle, one cycle after the internal state reaches cyc == 0, idx == 0. This includes the first slot after reset release.
- Elaboration checks (fatal):
  - SLOT_CYC % 2**DIM_W == 0
  - GUARD_CYC < SUB_CYC
  - 1 <= NDIG <= 16
- Reset mid-slot: all state returns to reset values immediately; scanning restarts at digit 0.

Optional Feature:
SEVENSEG_BLINK_EN.
- When defined:
  - Adds input blink (width NDIG) and parameter BLINK_FRAMES (default 250).
  - A frame counter increments at each frame_start event and toggles a phase bit every BLINK_FRAMES frames. The phase bit resets to 0 (visible).
  - While phase = 1, any digit whose blink bit is set is decoded as blank. blink is sampled at slot start with the digit code.
- When undefined: no blink port and no frame counter; behaviour is exactly as above.

Decomposition:
- Package sevenseg_pkg:
  - Field-position constants BLANK_B = 6, DP_B = 5, DASH_B = 4.
  - Typedef for the 7-bit digit code.
  - Hex-to-segment glyph constant array.
  - SEG_OFF = 7'h7F.
- One sub-module: the existing sevenseg_ext_n decoder, instanced on the latched code.
- Timing, PWM and scan logic stay inline.

Test Plan:
Bench parameters: NDIG = 4, CLK_HZ = 1_000_000, SLOT_US = 64 (SLOT_CYC = 64), DIM_W = 2 (SUB_CYC = 16), GUARD_CYC = 4.
- Reset held low then released:
  - Outputs at reset values: an_n = 4'hF, segs_n = 7'h7F, dp_n = 1.
  - frame_start pulses once in the first cycle after release.
  - an_n = 4'hE first appears 5 cycles after release.
- digits = {7'h03, 7'h02, 7'h01, 7'h00}, bright = 3:
  - an_n steps through E, D, B, 7 every 64 cycles, each low for 60 cycles.
  - segs_n shows glyphs 0, 1, 2, 3.
  - frame_start period is 256 cycles.
- bright = 0: each anode is low for 12 cycles per slot (cyc 4..15).
- bright changed from 0 to 3 at cyc = 30 of slot 1: slot 1 keeps 12 on-cycles; slot 2 has 60.
- Digit 2 = 7'h40 (blank) and digit 1 = 7'h10 (dash):
  - Slot 2 shows segs_n = 7'h7F, dp_n = 1.
  - Slot 1 shows segment g only lit.
- rst_n pulsed low for 1 cycle at idx = 2, cyc = 40: outputs reset asynchronously, and scanning restarts at digit 0 with a frame_start pulse.
